// File: rtl/tag_release_rob_pkg.sv
// Shared rename definitions.
// Contents:
//   TAG_W       - physical tag width. It is shared with the free list:
//                 clog2(128)+1.
//   tag_t       - physical tag type.
//   rob_entry_t - one retirement-tracker entry. It holds the valid,
//                 done and has_old flags and the superseded tag.
package tag_release_rob_pkg;

  localparam int unsigned TAG_W = 8;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    logic done;
    logic has_old;
    tag_t old_tag;
  } rob_entry_t;

endpackage

// File: rtl/tag_release_rob.sv
// In-order retirement tracker for the rename back end.
// It records, in program order, the physical tag that each newly allocated
// instruction supersedes. Instructions complete out of order. The oldest
// finished entry retires at a rate of at most one per cycle. A retiring
// entry returns its old tag to the free list.
//
// Ports:
//   clk, reset           - clock; synchronous, active-high reset
//   alloc_valid_0/1      - allocate one or two entries (slot 1 is younger)
//   alloc_has_old_0/1    - the slot supersedes a real tag
//   alloc_old_tag_0/1    - the tag to free when the slot retires
//   alloc_ready          - at least two entries are free
//   alloc_idx_0/1        - entry indices given to slot 0 and slot 1
//   complete_valid/_idx  - marks an in-flight entry as finished
//   release_valid/_tag   - free-list write port (write_tag/write_tag_source)
//   occupancy            - number of valid entries, 0..DEPTH
module tag_release_rob #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned TAG_W = tag_release_rob_pkg::TAG_W,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid_0,
  input  logic             alloc_valid_1,
  input  logic             alloc_has_old_0,
  input  logic             alloc_has_old_1,
  input  logic [TAG_W-1:0] alloc_old_tag_0,
  input  logic [TAG_W-1:0] alloc_old_tag_1,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx_0,
  output logic [IDX_W-1:0] alloc_idx_1,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_idx,
  output logic             release_valid,
  output logic [TAG_W-1:0] release_tag,
  output logic [IDX_W:0]   occupancy
);

  import tag_release_rob_pkg::*;

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  rob_entry_t       entries_q [DEPTH];
  rob_entry_t       entries_d [DEPTH];
  rob_entry_t       head_entry;
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] tail_p1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             release_valid_q, release_valid_d;
  logic [TAG_W-1:0] release_tag_q, release_tag_d;
  logic             do_alloc0, do_alloc1, do_retire, do_complete;

  // DEPTH is a power of two, so the index arithmetic wraps by itself.
  assign tail_p1     = tail_q + IDX_W'(1);
  // This depends only on count_q. A retirement in the same cycle does not
  // open a slot for allocation.
  assign alloc_ready = (count_q <= READY_MAX);
  assign do_alloc0   = alloc_valid_0 && alloc_ready;
  assign do_alloc1   = do_alloc0 && alloc_valid_1;
  assign head_entry  = entries_q[head_q];
  assign do_retire   = head_entry.valid && head_entry.done;
  assign do_complete = complete_valid && entries_q[complete_idx].valid &&
                       !entries_q[complete_idx].done;

  assign alloc_idx_0   = tail_q;
  assign alloc_idx_1   = tail_p1;
  assign occupancy     = count_q;
  assign release_valid = release_valid_q;
  assign release_tag   = release_tag_q;

  always_comb begin
    entries_d = entries_q;
    if (do_complete) begin
      entries_d[complete_idx].done = 1'b1;
    end
    if (do_retire) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].done  = 1'b0;
    end
    // When the tracker is full, head equals tail, but alloc_ready is low
    // then. Retire and allocate therefore never target the same entry.
    if (do_alloc0) begin
      entries_d[tail_q] = '{valid: 1'b1, done: 1'b0,
                            has_old: alloc_has_old_0, old_tag: alloc_old_tag_0};
    end
    if (do_alloc1) begin
      entries_d[tail_p1] = '{valid: 1'b1, done: 1'b0,
                             has_old: alloc_has_old_1, old_tag: alloc_old_tag_1};
    end

    head_d = do_retire ? (head_q + IDX_W'(1)) : head_q;
    if (do_alloc1) begin
      tail_d = tail_q + IDX_W'(2);
    end else if (do_alloc0) begin
      tail_d = tail_p1;
    end else begin
      tail_d = tail_q;
    end
    count_d = count_q + CNT_W'(do_alloc0) + CNT_W'(do_alloc1) - CNT_W'(do_retire);

    release_valid_d = do_retire && head_entry.has_old;
    release_tag_d   = do_retire ? head_entry.old_tag : release_tag_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      release_valid_q <= 1'b0;
      release_tag_q   <= '0;
    end else begin
      entries_q       <= entries_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      release_valid_q <= release_valid_d;
      release_tag_q   <= release_tag_d;
    end
  end

  // Protocol checks. An illegal request is dropped by the logic above.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_alloc_when_ready: assert (!alloc_valid_0 || alloc_ready);
      a_slot1_needs_slot0: assert (!alloc_valid_1 || alloc_valid_0);
      // This check also catches completion in the allocation cycle,
      // because the target entry is still invalid then.
      a_complete_target: assert (!complete_valid ||
                                 (entries_q[complete_idx].valid &&
                                  !entries_q[complete_idx].done));
    end
  end

endmodule

// File: tb/tb_tag_release_rob.sv
module tb_tag_release_rob;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_valid_0, alloc_valid_1;
  logic       alloc_has_old_0, alloc_has_old_1;
  logic [7:0] alloc_old_tag_0, alloc_old_tag_1;
  logic       alloc_ready;
  logic [4:0] alloc_idx_0, alloc_idx_1;
  logic       complete_valid;
  logic [4:0] complete_idx;
  logic       release_valid;
  logic [7:0] release_tag;
  logic [5:0] occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  tag_release_rob #(.DEPTH(32), .TAG_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .alloc_valid_0   (alloc_valid_0),
    .alloc_valid_1   (alloc_valid_1),
    .alloc_has_old_0 (alloc_has_old_0),
    .alloc_has_old_1 (alloc_has_old_1),
    .alloc_old_tag_0 (alloc_old_tag_0),
    .alloc_old_tag_1 (alloc_old_tag_1),
    .alloc_ready     (alloc_ready),
    .alloc_idx_0     (alloc_idx_0),
    .alloc_idx_1     (alloc_idx_1),
    .complete_valid  (complete_valid),
    .complete_idx    (complete_idx),
    .release_valid   (release_valid),
    .release_tag     (release_tag),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic v1, input logic h0, input logic [7:0] t0,
                       input logic h1, input logic [7:0] t1);
    alloc_valid_0 = 1'b1; alloc_valid_1 = v1;
    alloc_has_old_0 = h0; alloc_old_tag_0 = t0;
    alloc_has_old_1 = h1; alloc_old_tag_1 = t1;
  endtask

  task automatic alloc_off;
    alloc_valid_0 = 1'b0; alloc_valid_1 = 1'b0;
  endtask

  task automatic complete(input logic [4:0] idx);
    complete_valid = 1'b1; complete_idx = idx;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(alloc_ready), 32'd1);
    chk({tag, "_occ"},   32'(occupancy),   32'd0);
    chk({tag, "_idx0"},  32'(alloc_idx_0), 32'd0);
    chk({tag, "_idx1"},  32'(alloc_idx_1), 32'd1);
    chk({tag, "_rv"},    32'(release_valid), 32'd0);
    chk({tag, "_rtag"},  32'(release_tag), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid_0 = 1'b0; alloc_valid_1 = 1'b0;
    alloc_has_old_0 = 1'b0; alloc_has_old_1 = 1'b0;
    alloc_old_tag_0 = '0; alloc_old_tag_1 = '0;
    complete_valid = 1'b0; complete_idx = '0;

    // Reset and idle period
    tick; tick;
    reset = 1'b0;
    tick;
    check_reset_state("reset");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_rv", 32'(release_valid), 32'd0);
    end

    // In-order retirement with out-of-order completion
    alloc(1'b1, 1'b1, 8'h10, 1'b1, 8'h11);
    tick;
    chk("io_occ2", 32'(occupancy), 32'd2);
    chk("io_idx0", 32'(alloc_idx_0), 32'd2);
    alloc(1'b1, 1'b1, 8'h12, 1'b1, 8'h13);
    tick;
    alloc_off;
    chk("io_occ4", 32'(occupancy), 32'd4);
    complete(5'd3); tick; chk("io_rv_c3", 32'(release_valid), 32'd0);
    complete(5'd2); tick; chk("io_rv_c2", 32'(release_valid), 32'd0);
    complete(5'd1); tick; chk("io_rv_c1", 32'(release_valid), 32'd0);
    complete(5'd0); tick; chk("io_rv_c0", 32'(release_valid), 32'd0);
    complete_valid = 1'b0;
    tick;
    chk("io_rv_r0", 32'(release_valid), 32'd1); chk("io_tag_r0", 32'(release_tag), 32'h10);
    chk("io_occ_r0", 32'(occupancy), 32'd3);
    tick;
    chk("io_rv_r1", 32'(release_valid), 32'd1); chk("io_tag_r1", 32'(release_tag), 32'h11);
    tick;
    chk("io_rv_r2", 32'(release_valid), 32'd1); chk("io_tag_r2", 32'(release_tag), 32'h12);
    tick;
    chk("io_rv_r3", 32'(release_valid), 32'd1); chk("io_tag_r3", 32'(release_tag), 32'h13);
    chk("io_occ_r3", 32'(occupancy), 32'd0);
    tick;
    chk("io_rv_end", 32'(release_valid), 32'd0); chk("io_tag_hold", 32'(release_tag), 32'h13);

    // Entry without an old tag: it retires silently, but still takes a cycle
    alloc(1'b1, 1'b0, 8'h55, 1'b1, 8'h20);
    tick;
    alloc_off;
    chk("ho_occ", 32'(occupancy), 32'd2);
    chk("ho_idx0", 32'(alloc_idx_0), 32'd6);
    complete(5'd4); tick; chk("ho_rv_c4", 32'(release_valid), 32'd0);
    complete(5'd5); tick;
    complete_valid = 1'b0;
    chk("ho_rv_silent", 32'(release_valid), 32'd0);
    chk("ho_tag_silent", 32'(release_tag), 32'h55);
    chk("ho_occ1", 32'(occupancy), 32'd1);
    tick;
    chk("ho_rv_pulse", 32'(release_valid), 32'd1); chk("ho_tag_pulse", 32'(release_tag), 32'h20);
    tick;
    chk("ho_rv_end", 32'(release_valid), 32'd0);

    // Full tracker and index wrap-around
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      alloc(1'b1, 1'b1, 8'(8'h40 + 2 * i), 1'b1, 8'(8'h41 + 2 * i));
      tick;
    end
    chk("full_occ30", 32'(occupancy), 32'd30);
    chk("full_ready30", 32'(alloc_ready), 32'd1);
    chk("full_idx0_30", 32'(alloc_idx_0), 32'd30);
    alloc(1'b0, 1'b1, 8'h5E, 1'b0, 8'h00);
    tick;
    alloc_off;
    chk("full_occ31", 32'(occupancy), 32'd31);
    chk("full_ready31", 32'(alloc_ready), 32'd0);
    chk("wrap_idx0_31", 32'(alloc_idx_0), 32'd31);
    chk("wrap_idx1_31", 32'(alloc_idx_1), 32'd0);
    complete(5'd0); tick;
    complete(5'd1); tick;
    complete_valid = 1'b0;
    chk("full_rv_e0", 32'(release_valid), 32'd1); chk("full_tag_e0", 32'(release_tag), 32'h40);
    chk("full_occ_e0", 32'(occupancy), 32'd30);
    tick;
    chk("full_tag_e1", 32'(release_tag), 32'h41);
    chk("full_occ29", 32'(occupancy), 32'd29);
    alloc(1'b0, 1'b1, 8'h5F, 1'b0, 8'h00);
    tick;
    chk("wrap_occ30", 32'(occupancy), 32'd30);
    chk("wrap_idx0", 32'(alloc_idx_0), 32'd0);
    chk("wrap_idx1", 32'(alloc_idx_1), 32'd1);
    alloc(1'b1, 1'b1, 8'h60, 1'b1, 8'h61);
    tick;
    alloc_off;
    chk("full_occ32", 32'(occupancy), 32'd32);
    chk("full_ready32", 32'(alloc_ready), 32'd0);
    chk("full_idx0_32", 32'(alloc_idx_0), 32'd2);

    // Allocate and retire in the same cycle
    complete(5'd2); tick;
    chk("sim_rv_e5", 32'(release_valid), 32'd0);
    complete(5'd3); tick;
    chk("sim_tag_e6", 32'(release_tag), 32'h42);
    complete(5'd4); tick;
    complete_valid = 1'b0;
    chk("sim_tag_e7", 32'(release_tag), 32'h43);
    chk("sim_occ30", 32'(occupancy), 32'd30);
    chk("sim_ready30", 32'(alloc_ready), 32'd1);
    alloc(1'b1, 1'b1, 8'h70, 1'b1, 8'h71);
    tick;
    alloc_off;
    chk("sim_occ31", 32'(occupancy), 32'd31);
    chk("sim_ready31", 32'(alloc_ready), 32'd0);
    chk("sim_rv", 32'(release_valid), 32'd1);
    chk("sim_tag", 32'(release_tag), 32'h44);
    chk("sim_idx0", 32'(alloc_idx_0), 32'd4);
    tick;
    chk("sim_rv_after", 32'(release_valid), 32'd0);
    chk("sim_occ_after", 32'(occupancy), 32'd31);

    // Reset while entries are in flight
    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc(1'b1, 1'b1, 8'(8'h80 + 2 * i), 1'b1, 8'(8'h81 + 2 * i));
      tick;
    end
    alloc_off;
    chk("mid_occ8", 32'(occupancy), 32'd8);
    complete(5'd0); tick;
    complete(5'd2); tick;
    chk("mid_tag0", 32'(release_tag), 32'h80);
    complete(5'd3); tick;
    complete(5'd5); tick;
    complete(5'd6); tick;
    complete_valid = 1'b0;
    chk("mid_rv_pre", 32'(release_valid), 32'd0);
    chk("mid_tag_pre", 32'(release_tag), 32'h80);
    chk("mid_occ7", 32'(occupancy), 32'd7);
    // Other requests during reset must have no effect.
    reset = 1'b1;
    alloc(1'b1, 1'b1, 8'hAA, 1'b1, 8'hAB);
    complete(5'd1);
    tick;
    reset = 1'b0;
    alloc_off;
    complete_valid = 1'b0;
    check_reset_state("mid_reset");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("mid_idle_rv", 32'(release_valid), 32'd0);
    end
    chk("mid_idle_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_release_rob.md
Name: tag_release_rob

Overview:
- In-order retirement tracker for the renaming back end; the producer side of the tag free-list write port.
- The allocator hands out up to 2 new physical tags per cycle. For each one it records the tag being superseded (the old mapping) in program order.
- Instructions complete out of order. Entries retire strictly in order.
- Each retiring entry returns its old tag to the free list through write_tag/write_tag_source, at most one per cycle.

Parameters:
DEPTH, 32, number of in-flight entries; must be a power of 2, >= 4
TAG_W, 8, physical tag width; equals clog2(128)+1 to match the free-list tag width
IDX_W, clog2(DEPTH), entry index width (derived; not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
alloc_valid_0  in  1  allocate slot 0 this cycle
alloc_valid_1  in  1  allocate slot 1 this cycle (younger than slot 0); legal only with alloc_valid_0
alloc_has_old_0  in  1  slot 0 supersedes a real tag
alloc_has_old_1  in  1  slot 1 supersedes a real tag
alloc_old_tag_0  in  TAG_W  tag to free when slot 0 retires
alloc_old_tag_1  in  TAG_W  tag to free when slot 1 retires
alloc_ready  out  1  at least 2 free entries
alloc_idx_0  out  IDX_W  index given to slot 0 (= tail)
alloc_idx_1  out  IDX_W  index given to slot 1 (= tail+1 mod DEPTH)
complete_valid  in  1  an entry has finished execution
complete_idx  in  IDX_W  index of the finished entry
release_valid  out  1  drives free-list write_tag
release_tag  out  TAG_W  drives free-list write_tag_source
occupancy  out  IDX_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: per entry, valid, done, has_old and old_tag. Pointers: head (oldest), tail (next free), and a count register.
- Reset values: head=0, tail=0, count=0, all valid=0, all done=0, release_valid=0, release_tag=0.
  - Consequences: alloc_ready=1, occupancy=0, alloc_idx_0=0, alloc_idx_1=1.
  - Reset takes priority over every other input in the same cycle. Entries in flight are discarded and their old tags are not released.
- alloc_ready = (DEPTH - count) >= 2, combinational from count only. It does not depend on same-cycle retirement.
- Allocation: happens on a clock edge when alloc_valid_0 && alloc_ready.
  - entry[tail] is written with valid=1, done=0 and the slot-0 fields. If alloc_valid_1 is set, entry[tail+1] gets the slot-1 fields.
  - tail advances by 1 or 2, wrapping mod DEPTH.
  - Allocating while alloc_ready=0 is a protocol error: the request is ignored and an assertion fires.
  - alloc_valid_1 without alloc_valid_0: ignored, assertion fires.
- Completion: complete_valid sets done on entry[complete_idx] at the clock edge.
  - If the target entry is not valid, or already done: ignored, assertion fires.
  - Completing an entry in the same cycle it is allocated is illegal.
- Retirement: at most 1 entry per cycle. The head retires when entry[head].valid && entry[head].done at the start of the cycle.
  - On retirement: valid is cleared, head advances mod DEPTH, and next-cycle release_valid = has_old, release_tag = old_tag.
  - If nothing retires, release_valid=0 next cycle. release_tag holds its last value.
- Latency: complete_valid on the head at edge N gives done=1 after N, retirement at edge N+1, and release_valid high in the cycle after N+1.
  - Minimum complete-to-release is 2 edges.
  - A backlog of k done entries drains at 1 per cycle.
- Entries with has_old=0 still retire and consume a cycle, but do not pulse release_valid.
- Count update: count_next = count + allocs - retire. Simultaneous allocate and retire is legal. At count=DEPTH-1, alloc_ready=0 even if a retire is happening that cycle.
- Full: count=DEPTH, alloc_ready=0, occupancy=DEPTH. Empty: count=0, no retirement.
- Wrap-around: with tail=DEPTH-1 and two allocations, alloc_idx_1=0 and tail becomes 1.
- The free list accepts one write per cycle, so there is no backpressure on release_valid.

Decomposition:
- Shared rename package: TAG_W and the tag typedef (shared with the free list), plus an entry struct {valid, done, has_old, old_tag}.
- No sub-module. Storage, pointers and retire logic stay in one module.

Test Plan:
- Reset: after reset, alloc_ready=1, occupancy=0, alloc_idx_0/1=0/1, release_valid=0 for 10 idle cycles.
- In-order retire: allocate pairs (old 0x10,0x11), then (0x12,0x13); complete idx 3,2,1,0 on consecutive edges. Required: no release until idx0 is done, then release_tag 0x10,0x11,0x12,0x13 on 4 consecutive cycles.
- has_old=0: allocate idx0 (has_old=0) and idx1 (old 0x20); complete both. Required: exactly one release_valid pulse with tag 0x20, one cycle later than if idx0 had released.
- Full and wrap: fill 32 entries, confirm alloc_ready drops at occupancy 31. Retire 2, allocate a pair at tail=0 and confirm idx 0,1 are reused. Separately, start with tail=31: alloc_idx_1=0.
- Simultaneous events: at occupancy 30 with the head done, allocate 2 and retire 1 in the same cycle. Required: occupancy becomes 31, alloc_ready=0, and one release follows.
- Reset mid-flight: 8 entries allocated, 4 of them done, assert reset for 1 cycle. Required: no release pulses afterwards and all reset values are restored.
